// File: rtl/bps_iter_sched.sv
`default_nettype none
// ============================================================================
// Module   : bps_iter_sched
// Purpose  : Iteration scheduler for one BP-S unit. After a start it issues
//            one LOAD pass, then a number of rounds of DOWN, STORE_DOWN, UP
//            and STORE_UP passes, then pulses done. Only one opcode is in
//            flight at a time; the next one waits until the unit drops
//            bps_stall. Supports abort, a per-pass watchdog and progress
//            reporting.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            start         - begin a schedule (accepted only in IDLE)
//            iterations    - number of rounds, captured on accepted start
//            abort         - request early stop at the next round boundary
//            busy          - high whenever the scheduler is not idle
//            done          - one-cycle pulse at completion (normal or abort)
//            aborted       - run ended by abort (held until next start)
//            error         - sticky watchdog error (cleared on next start)
//            iter_count    - rounds completed in the current/last run
//            bps_opcode    - opcode to the unit, valid for one cycle
//            bps_stall     - unit busy with the current pass
// Revision : 1.0 - initial release
// ============================================================================
module bps_iter_sched #(
    parameter int ITER_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] iterations,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              error,
    output logic [ITER_W-1:0] iter_count,
    output logic [2:0]        bps_opcode,
    input  logic              bps_stall
);

    localparam logic [2:0] c_op_idle = 3'd0;
    localparam logic [2:0] c_op_load = 3'd1;
    localparam logic [2:0] c_op_down = 3'd2;
    localparam logic [2:0] c_op_up   = 3'd3;
    localparam logic [2:0] c_op_sdn  = 3'd4;
    localparam logic [2:0] c_op_sup  = 3'd5;

    // Last watchdog value tolerated while the unit still stalls.
    localparam logic [TO_W-1:0] c_wd_last = TO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_LOAD_W = 4'd2,
        S_DOWN   = 4'd3,
        S_DOWN_W = 4'd4,
        S_SDN    = 4'd5,
        S_SDN_W  = 4'd6,
        S_UP     = 4'd7,
        S_UP_W   = 4'd8,
        S_SUP    = 4'd9,
        S_SUP_W  = 4'd10,
        S_FIN    = 4'd11
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ITER_W-1:0]   r_iter_target;
    logic [ITER_W-1:0]   r_iter_count;
    logic                r_abort_pending;
    logic                r_aborted;
    logic                r_error;
    logic [TO_W-1:0]     r_wd;
    logic                w_issuing;
    logic                w_waiting;
    logic                w_wd_expired;
    logic                w_round_last;
    logic                w_accept;

    assign w_accept     = (r_state == S_IDLE) && start;
    // Current round is the final one; count < target always holds here, so
    // the increment cannot wrap.
    assign w_round_last = (r_iter_count + ITER_W'(1)) == r_iter_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        bps_opcode   = c_op_idle;
        w_issuing    = 1'b0;
        w_waiting    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                bps_opcode   = c_op_load;
                w_issuing    = 1'b1;
                w_next_state = S_LOAD_W;
            end
            S_LOAD_W: begin
                w_waiting = 1'b1;
                if (!bps_stall) begin
                    w_next_state = ((r_iter_target == '0) || r_abort_pending) ? S_FIN : S_DOWN;
                end
            end
            S_DOWN: begin
                bps_opcode   = c_op_down;
                w_issuing    = 1'b1;
                w_next_state = S_DOWN_W;
            end
            S_DOWN_W: begin
                w_waiting = 1'b1;
                if (!bps_stall) begin
                    w_next_state = S_SDN;
                end
            end
            S_SDN: begin
                bps_opcode   = c_op_sdn;
                w_issuing    = 1'b1;
                w_next_state = S_SDN_W;
            end
            S_SDN_W: begin
                w_waiting = 1'b1;
                if (!bps_stall) begin
                    w_next_state = S_UP;
                end
            end
            S_UP: begin
                bps_opcode   = c_op_up;
                w_issuing    = 1'b1;
                w_next_state = S_UP_W;
            end
            S_UP_W: begin
                w_waiting = 1'b1;
                if (!bps_stall) begin
                    w_next_state = S_SUP;
                end
            end
            S_SUP: begin
                bps_opcode   = c_op_sup;
                w_issuing    = 1'b1;
                w_next_state = S_SUP_W;
            end
            S_SUP_W: begin
                w_waiting = 1'b1;
                // Abort is only honoured at round boundaries so the stored
                // messages always reflect complete rounds.
                if (!bps_stall) begin
                    w_next_state = (r_abort_pending || w_round_last) ? S_FIN : S_DOWN;
                end
            end
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // A pass that overstays its budget abandons the run with no done.
        w_wd_expired = w_waiting && bps_stall && (r_wd == c_wd_last);
        if (w_wd_expired) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter_target   <= '0;
            r_iter_count    <= '0;
            r_abort_pending <= 1'b0;
            r_aborted       <= 1'b0;
            r_error         <= 1'b0;
            r_wd            <= '0;
        end else begin
            if (w_accept) begin
                r_iter_target   <= iterations;
                r_iter_count    <= '0;
                r_aborted       <= 1'b0;
                r_error         <= 1'b0;
                r_abort_pending <= 1'b0;
            end else if ((r_state != S_IDLE) && abort) begin
                r_abort_pending <= 1'b1;
            end

            if (w_issuing) begin
                r_wd <= '0;
            end else if (w_waiting && bps_stall) begin
                r_wd <= r_wd + TO_W'(1);
            end

            if (w_wd_expired) begin
                r_error <= 1'b1;
            end

            if ((r_state == S_SUP_W) && !bps_stall && !w_wd_expired) begin
                r_iter_count <= r_iter_count + ITER_W'(1);
            end

            // aborted becomes visible together with the done pulse in FIN.
            if (w_next_state == S_FIN) begin
                r_aborted <= r_abort_pending;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);
    assign aborted    = r_aborted;
    assign error      = r_error;
    assign iter_count = r_iter_count;

endmodule
`default_nettype wire

// File: tb/tb_bps_iter_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bps_iter_sched
// Purpose  : Self-checking bench for bps_iter_sched. Contains a model of the
//            BP-S unit (stall for a chosen number of cycles per pass) and a
//            reference model computing the expected opcode sequence, issue
//            cycles, progress count and completion cycle from the pass
//            lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bps_iter_sched;

    localparam int ITER_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;
    localparam int LIMIT   = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ITER_W-1:0] iterations;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              error;
    logic [ITER_W-1:0] iter_count;
    logic [2:0]        bps_opcode;
    logic              bps_stall;

    bps_iter_sched #(
        .ITER_W  (ITER_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .iterations (iterations),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .error      (error),
        .iter_count (iter_count),
        .bps_opcode (bps_opcode),
        .bps_stall  (bps_stall)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Stimulus-owned
    int lens[$];
    bit hang;

    // Monitor-owned
    int cyc;
    int run_start;
    int op_log[$];
    int cyc_log[$];
    int ic_log[$];
    int done_n;
    int done_cyc;
    int done_ic;
    int done_ab;
    int err_rise;
    int viol;

    typedef struct {
        int iters;
        int slen;
        int ab_round;
        int poke;
        int exp_done;
        int exp_ic;
        int exp_ab;
    } vec_t;

    vec_t vecs[8];
    int   opseq[4] = '{2, 4, 3, 5};

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic bound_chk(input string nm, input int used, input int lim);
        tests++;
        if (used >= lim) begin
            fails++;
            $display("FAIL %s: waited %0d cycles, limit %0d", nm, used, lim);
        end
    endtask

    // BP-S unit model and observer. Runs 1 time unit after each rising edge.
    // A pass of length L keeps stall high for L cycles starting the cycle
    // after the opcode.
    initial begin
        int  rem;
        int  pend_len;
        bit  pend;
        bit  hold;
        bit  prev_busy;
        rem = 0; pend_len = 1; pend = 0; hold = 0; prev_busy = 0;
        cyc = 0; run_start = 0; done_n = 0; done_cyc = -1; done_ic = -1;
        done_ab = -1; err_rise = -1; viol = 0;
        bps_stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                bps_stall = 1'b0; rem = 0; pend = 0; hold = 0; prev_busy = 0;
            end else begin
                if (busy && !prev_busy) begin
                    run_start = cyc - 1;
                    op_log.delete(); cyc_log.delete(); ic_log.delete();
                    done_n = 0; done_cyc = -1; done_ic = -1; done_ab = -1;
                    err_rise = -1; viol = 0;
                end
                prev_busy = busy;
                if (!hang) hold = 0;
                if (pend) begin
                    bps_stall = 1'b1; rem = pend_len - 1; pend = 0;
                end else if (bps_stall && !hold) begin
                    if (rem > 0) rem--;
                    else bps_stall = 1'b0;
                end
                if (bps_opcode != 3'd0) begin
                    if (bps_stall) viol++;
                    op_log.push_back(int'(bps_opcode));
                    cyc_log.push_back(cyc - run_start);
                    ic_log.push_back(int'(iter_count));
                    pend = 1;
                    if (hang && bps_opcode == 3'd2) begin
                        hold = 1; pend_len = 1;
                    end else if (op_log.size() <= lens.size()) begin
                        pend_len = lens[op_log.size() - 1];
                    end else begin
                        pend_len = 1;
                    end
                end
                if (done) begin
                    done_n++; done_cyc = cyc - run_start;
                    done_ic = int'(iter_count); done_ab = int'(aborted);
                end
                if (error && err_rise < 0) err_rise = cyc - run_start;
            end
        end
    end

    // One full run. e_done < 0 means expectations come from the model only.
    task automatic run_one(input int n, input int ab, input int poke,
                           input int e_done, input int e_ic, input int e_ab);
        int  r, p, t, budget, lim;
        bit  ab_sent;
        int  x_op[$];
        int  x_cyc[$];
        int  x_ic[$];
        int  m_done, m_ic, m_ab;

        // Reference: rounds actually run, then each pass takes issue + L
        // stall cycles + release cycle before the next issue.
        r = (ab > 0 && ab <= n) ? ab : n;
        p = 1 + 4 * r;
        t = 1;
        for (int k = 0; k < p; k++) begin
            x_op.push_back(k == 0 ? 1 : opseq[(k - 1) % 4]);
            x_cyc.push_back(t);
            x_ic.push_back(k == 0 ? 0 : (k - 1) / 4);
            t += lens[k] + 2;
        end
        m_done = t;
        m_ic   = r;
        m_ab   = (ab > 0 && ab <= n) ? 1 : 0;
        if (e_done >= 0) begin
            m_done = e_done; m_ic = e_ic; m_ab = e_ab;
        end

        @(negedge clk);
        iterations = ITER_W'(n);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_clr_aborted", int'(aborted), 0);
        chk("start_clr_error", int'(error), 0);

        budget  = 0;
        ab_sent = 0;
        while (!(done_n > 0 && !busy) && budget < LIMIT) begin
            @(negedge clk);
            budget++;
            start = 1'b0;
            abort = 1'b0;
            // Abort lands in the DOWN pass wait of the chosen round.
            if (ab > 0 && !ab_sent && op_log.size() == 2 + 4 * (ab - 1) && bps_stall) begin
                abort = 1'b1; ab_sent = 1;
            end
            if (poke != 0 && (cyc - run_start) == 2) begin
                start = 1'b1; iterations = ITER_W'(7);
            end
            if (poke != 0 && done) begin
                start = 1'b1; iterations = ITER_W'(3);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        bound_chk("run_budget", budget, LIMIT);

        chk("num_opcodes", op_log.size(), p);
        lim = (op_log.size() < p) ? op_log.size() : p;
        for (int k = 0; k < lim; k++) begin
            chk($sformatf("op[%0d]", k), op_log[k], x_op[k]);
            chk($sformatf("op_cycle[%0d]", k), cyc_log[k], x_cyc[k]);
            chk($sformatf("progress[%0d]", k), ic_log[k], x_ic[k]);
        end
        chk("done_pulses", done_n, 1);
        chk("done_cycle", done_cyc, m_done);
        chk("done_iter_count", done_ic, m_ic);
        chk("done_aborted", done_ab, m_ab);
        chk("stall_overlap", viol, 0);
        chk("end_error", int'(error), 0);
        chk("end_busy", int'(busy), 0);
        chk("hold_aborted", int'(aborted), m_ab);
        chk("hold_iter_count", int'(iter_count), m_ic);
    endtask

    initial begin
        int n, ab, budget, d, n_up;

        rst = 1'b1; start = 1'b0; abort = 1'b0; iterations = '0; hang = 0;

        vecs[0] = '{iters: 2,   slen: 1,  ab_round: 0, poke: 0, exp_done: 28,   exp_ic: 2,   exp_ab: 0};
        vecs[1] = '{iters: 0,   slen: 1,  ab_round: 0, poke: 0, exp_done: 4,    exp_ic: 0,   exp_ab: 0};
        vecs[2] = '{iters: 5,   slen: 1,  ab_round: 2, poke: 0, exp_done: 28,   exp_ic: 2,   exp_ab: 1};
        vecs[3] = '{iters: 1,   slen: 3,  ab_round: 0, poke: 0, exp_done: 26,   exp_ic: 1,   exp_ab: 0};
        vecs[4] = '{iters: 3,   slen: 15, ab_round: 0, poke: 0, exp_done: 222,  exp_ic: 3,   exp_ab: 0};
        vecs[5] = '{iters: 1,   slen: 1,  ab_round: 1, poke: 0, exp_done: 16,   exp_ic: 1,   exp_ab: 1};
        vecs[6] = '{iters: 2,   slen: 1,  ab_round: 0, poke: 1, exp_done: 28,   exp_ic: 2,   exp_ab: 0};
        vecs[7] = '{iters: 255, slen: 1,  ab_round: 0, poke: 0, exp_done: 3064, exp_ic: 255, exp_ab: 0};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_iter_count", int'(iter_count), 0);
        chk("rst_opcode", int'(bps_opcode), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Table-driven runs with uniform pass length.
        for (int v = 0; v < 8; v++) begin
            lens.delete();
            for (int k = 0; k < 1 + 4 * vecs[v].iters; k++) lens.push_back(vecs[v].slen);
            run_one(vecs[v].iters, vecs[v].ab_round, vecs[v].poke,
                    vecs[v].exp_done, vecs[v].exp_ic, vecs[v].exp_ab);
        end

        // Randomised runs: random pass lengths below the watchdog limit.
        for (int rr = 0; rr < 8; rr++) begin
            n  = (rr == 0) ? 3 : int'($urandom_range(0, 6));
            ab = (rr > 0 && n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
            lens.delete();
            for (int k = 0; k < 1 + 4 * n; k++) lens.push_back(int'($urandom_range(1, TIMEOUT - 1)));
            run_one(n, ab, 0, -1, -1, -1);
        end

        // Watchdog: the first DOWN pass never releases. The stall is seen high
        // for TIMEOUT cycles; error is set at the edge closing the last of
        // them, so it is first visible TIMEOUT+1 cycles after the DOWN issue.
        lens.delete();
        repeat (9) lens.push_back(1);
        hang = 1;
        @(negedge clk);
        iterations = ITER_W'(2);
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        while (!error && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        bound_chk("wd_budget", budget, 200);
        d = -1000;
        for (int k = 0; k < op_log.size(); k++) begin
            if (op_log[k] == 2 && d == -1000) d = cyc_log[k];
        end
        chk("wd_error_cycle", err_rise, d + TIMEOUT + 1);
        chk("wd_busy", int'(busy), 0);
        chk("wd_opcode", int'(bps_opcode), 0);
        chk("wd_no_done", done_n, 0);
        chk("wd_iter_count", int'(iter_count), 0);
        chk("wd_num_opcodes", op_log.size(), 2);
        repeat (3) @(negedge clk);
        chk("wd_sticky", int'(error), 1);
        hang = 0;
        repeat (2) @(negedge clk);
        lens.delete();
        lens.push_back(1);
        run_one(0, 0, 0, 4, 0, 0);

        // Reset during the UP pass wait of round 2.
        lens.delete();
        repeat (13) lens.push_back(5);
        @(negedge clk);
        iterations = ITER_W'(3);
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        n_up   = 0;
        while (!(n_up == 2 && bps_stall) && budget < 500) begin
            @(negedge clk);
            budget++;
            n_up = 0;
            for (int k = 0; k < op_log.size(); k++) if (op_log[k] == 3) n_up++;
        end
        bound_chk("rst_run_budget", budget, 500);
        chk("pre_rst_iter_count", int'(iter_count), 1);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_aborted", int'(aborted), 0);
        chk("midrst_error", int'(error), 0);
        chk("midrst_iter_count", int'(iter_count), 0);
        chk("midrst_opcode", int'(bps_opcode), 0);
        lens.delete();
        repeat (9) lens.push_back(1);
        run_one(2, 0, 0, 28, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
